// File: rtl/hex_display_scanner_pkg.sv
// hex_display_pkg
//   Shared constants and the hex font used by the seven-segment scanner and
//   any other status display that needs to render a nibble.
//   Segment vectors are ordered {g,f,e,d,c,b,a}. All patterns are active low
//   because the board uses common-anode digits.
package hex_display_pkg;

    typedef logic [6:0] seg_n_t;

    // All segments dark.
    localparam seg_n_t SEG_OFF = 7'h7F;

    // Bit position of each segment inside a seg_n_t.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Hex font, returned active low. The table below lists the lit set
    // (active high, gfedcba) and the result is its complement.
    function automatic seg_n_t hex_to_seg_n(input logic [3:0] nibble);
        seg_n_t lit;
        case (nibble)
            4'h0:    lit = 7'b0111111;
            4'h1:    lit = 7'b0000110;
            4'h2:    lit = 7'b1011011;
            4'h3:    lit = 7'b1001111;
            4'h4:    lit = 7'b1100110;
            4'h5:    lit = 7'b1101101;
            4'h6:    lit = 7'b1111101;
            4'h7:    lit = 7'b0000111;
            4'h8:    lit = 7'b1111111;
            4'h9:    lit = 7'b1101111;
            4'hA:    lit = 7'b1110111;
            4'hB:    lit = 7'b1111100;
            4'hC:    lit = 7'b0111001;
            4'hD:    lit = 7'b1011110;
            4'hE:    lit = 7'b1111001;
            default: lit = 7'b1110001;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if
//   Load channel of the hex display scanner.
//   value_in   : packed nibbles, nibble k drives digit k
//   load_valid : value_in is presented
//   load_ready : scanner's pending register is empty
//   master = register/control side, slave = scanner.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load_valid;
    logic                    load_ready;

    modport master (
        output value_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  value_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/hex_display_scanner_seg_lut.sv
// hex_seg_lut
//   Combinational nibble -> active-low seven-segment pattern.
//   nibble : hex digit to render
//   seg_n  : {g,f,e,d,c,b,a}, low = lit
module hex_seg_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_n_t     seg_n
);
    assign seg_n = hex_to_seg_n(nibble);
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexed driver for NUM_DIGITS common-anode digits on one shared
//   segment bus. A value accepted on the load channel waits in a pending
//   register and is copied to the displayed (shadow) register only when the
//   scan wraps back to digit 0, so every frame shows one coherent value.
//
//   Ports
//     clk, reset : clock, synchronous active-high reset
//     bus        : load channel (value_in / load_valid / load_ready)
//     seg        : active-low segments {g,f,e,d,c,b,a}, registered
//     an         : active-low one-hot digit enable, registered
//     frame_tick : one-cycle pulse in the cycle after each frame boundary
//
//   Build option
//     HEX_DISPLAY_LEADING_ZERO_BLANK_EN : blank digit k>0 when it and every
//     higher nibble are zero. Scan timing is unaffected.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_scanner_if.slave  bus,
    output seg_n_t                seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [VW-1:0] shadow;
    logic [VW-1:0] pend;
    logic          pend_full;

    logic term;
    logic boundary;

    assign term     = (cnt == CNT_LAST);
    assign boundary = term && (idx == IDX_LAST);

    assign bus.load_ready = ~pend_full;

    // One font lookup per digit; the scan mux picks the active lane.
    seg_n_t [NUM_DIGITS-1:0] lane_seg;
    logic   [NUM_DIGITS-1:0] blank;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
        hex_seg_lut u_lut (
            .nibble (shadow[4*k +: 4]),
            .seg_n  (lane_seg[k])
        );

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and everything above it is zero.
        if (k == 0) begin : g_keep
            assign blank[k] = 1'b0;
        end else begin : g_lz
            assign blank[k] = ~|shadow[VW-1:4*k];
        end
`else
        assign blank[k] = 1'b0;
`endif
    end

    seg_n_t                seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                an_nxt[k] = 1'b0;
                seg_nxt   = blank[k] ? SEG_OFF : lane_seg[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            seg        <= SEG_OFF;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            // Refresh counter and digit index.
            if (term) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Commit and capture are exclusive: capture needs pending empty,
            // commit needs it full. A load landing on a boundary therefore
            // waits for the following boundary.
            if (boundary && pend_full) begin
                shadow    <= pend;
                pend_full <= 1'b0;
            end else if (bus.load_valid && !pend_full) begin
                pend      <= bus.value_in;
                pend_full <= 1'b1;
            end

            // Outputs show the pre-edge index/shadow: one cycle of latency.
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= boundary;
        end
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits that share one segment bus.
- Accepts a packed hex value through a valid/ready handshake and holds it in a pending register.
- The pending value is committed to the displayed (shadow) register only at a frame boundary, so a frame never shows a mix of old and new digits.
- Sits between register/control logic and the board display pins; it replaces per-digit static decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles each digit stays lit; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  packed nibbles; nibble k (bits 4k+3:4k) drives digit k; bit 4k+3 is the MSB.
- load_valid  in  1  value_in is presented.
- load_ready  out  1  pending register is empty and can accept a value.
- seg  out  7  active-low segments; bits 6..0 = g f e d c b a.
- an  out  NUM_DIGITS  active-low one-hot digit enable.
- frame_tick  out  1  one-cycle pulse on each frame boundary.

Behaviour:
- Reset values: seg=7'h7F, an=all ones, frame_tick=0, load_ready=1. Refresh counter=0, digit index=0, shadow=0, pending empty.
- Reset asserted mid-operation discards any pending value and blanks the display on the next edge.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and the digit index advances.
  - The digit index wraps from NUM_DIGITS-1 to 0; that wrap cycle is the frame boundary.
  - REFRESH_DIV=1: the index advances every cycle. NUM_DIGITS=1: every terminal count is a frame boundary.
- Handshake and commit:
  - A transfer occurs when load_valid & load_ready. value_in is captured into pending, and load_ready drops on the next cycle.
  - At a frame boundary with pending full: shadow <= pending, pending clears, load_ready=1 from the next cycle.
  - Transfer and frame boundary in the same cycle: there is no bypass. The value goes to pending and commits at the following boundary.
  - Changes on value_in while load_ready=0 are ignored.
- Outputs:
  - seg, an and frame_tick are registered. They reflect the digit index and shadow one cycle later, i.e. 1-cycle latency.
  - an has exactly one bit low after the first post-reset edge: an[k]=0 for digit index k.
  - frame_tick is high in the cycle after a boundary.
- Font (active-high lit set; seg drives its complement):
  - 0: a b c d e f
  - 1: b c
  - 2: a b d e g
  - 3: a b c d g
  - 4: b c f g
  - 5: a c d f g
  - 6: a c d e f g
  - 7: a b c
  - 8: all
  - 9: a b c d f g
  - A: a b c e f g
  - b: c d e f g
  - C: a d e f
  - d: b c d e g
  - E: a d e f g
  - F: a e f g
- Widths:
  - Digit index width = max(1, clog2(NUM_DIGITS)).
  - Counter width = max(1, clog2(REFRESH_DIV)).
  - No arithmetic on the displayed data.

Optional Feature:
- Macro: HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 is blanked (seg=7'h7F, an still one-hot) when its shadow nibble and every higher nibble are zero. Digit 0 is never blanked.
  - Example: shadow 0x0050 shows digits 1 and 0 only.
- Undefined: all digits always show their font pattern.
- Scan timing is identical in both builds.

Decomposition:
- Package hex_display_pkg holds:
  - SEG_OFF constant 7'h7F.
  - Segment bit index constants A..G.
  - Font function hex_to_seg_n(nibble) returning the active-low pattern.
- Sub-module hex_seg_lut (combinational nibble -> active-low seg, wraps the package function).
  - Reused by future status displays.

Test Plan:
- Bench parameters NUM_DIGITS=4, REFRESH_DIV=4.
- Reset release: seg=7'h7F and an=4'hF during reset. Next edge an=4'hE, seg=7'h40 (digit 0 shows '0'). an rotates E,D,B,7 every 4 cycles. frame_tick pulses every 16 cycles.
- Load 0x12AF mid-frame: load_ready=0 until the boundary, display unchanged. After commit, digits 0..3 show seg=7'h0E, 7'h08, 7'h24, 7'h79 (F, A, 2, 1). load_ready=1 after the boundary.
- load_valid asserted exactly on a boundary cycle with 0x8888: committed at the next boundary, not the current one. An intermediate frame shows the prior value; after commit all digits show seg=7'h00.
- Second load_valid (0x1111) held while load_ready=0: not captured. After ready returns, the held value is accepted and shown one frame later.
- Reset asserted while pending=0x5555: outputs blank next edge, pending lost. After release the display shows 0000 and load_ready=1.
- With HEX_DISPLAY_LEADING_ZERO_BLANK_EN, load 0x0050: digits 3 and 2 show seg=7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40.
